// File: rtl/wac_spi_pkg.sv
// wac_spi_pkg: state encoding, channel indices and counter sizing for the SPI scheduler
package wac_spi_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT_LO, ST_SHIFT_HI, ST_HOLD, ST_GAP} stateT;
  localparam logic [1:0] CH_DAC = 2'd0;
  localparam logic [1:0] CH_POT1 = 2'd1;
  localparam logic [1:0] CH_POT2 = 2'd2;
  localparam logic [1:0] CH_POT3 = 2'd3;
  localparam int DAC_BITS_DEF = 24;
  localparam int CNT_W = 16;
  function automatic int bitCntW(input int bits);
    return $clog2(bits + 1);
  endfunction
  localparam int BIT_CNT_W = bitCntW(DAC_BITS_DEF);
endpackage

// File: rtl/wac_spi_scheduler_rr_arbiter.sv
// wac_spi_rr_arbiter: 4-way round-robin grant, pointer advances past each granted channel
module wac_spi_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] reqValid,
  input  logic       grantEn,
  output logic [3:0] grant,
  output logic [1:0] grantIdx,
  output logic       anyReq
);
  logic [1:0] ptr;
  always_comb begin
    grantIdx = ptr;
    for (int i = 3; i >= 0; i--) grantIdx = reqValid[ptr + 2'(i)] ? ptr + 2'(i) : grantIdx;
  end
  assign anyReq = |reqValid;
  assign grant = anyReq ? 4'b0001 << grantIdx : 4'b0000;
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (grantEn) ptr <= grantIdx + 2'd1;
endmodule

// File: rtl/wac_spi_scheduler.sv
// wac_spi_scheduler: arbitrates DAC/digipot requests and serialises one frame at a time
module wac_spi_scheduler
  import wac_spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int DAC_BITS = 24,
  parameter int POT_BITS = 16,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            reqValid,
  input  logic [4*DAC_BITS-1:0] reqData,
  output logic [3:0]            reqAck,
  output logic                  busy,
  output logic                  done,
  output logic                  syncDac,
  output logic                  sclkDac,
  output logic                  sdiDac,
  output logic                  csDpot1,
  output logic                  csDpot2,
  output logic                  csDpot3,
  output logic                  clkDpot,
  output logic                  sdiDpot
);
  localparam int BCW = bitCntW(DAC_BITS);
  stateT state;
  logic [CNT_W-1:0] cnt;
  logic [BCW-1:0] bitCnt;
  logic [DAC_BITS-1:0] shiftReg, word, loadWord;
  logic [2:0] csN;
  logic [3:0] grant;
  logic [1:0] grantIdx;
  logic anyReq, isPot, grantPot;
  wac_spi_rr_arbiter arb (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .grantEn(state == ST_IDLE && anyReq),
    .grant(grant), .grantIdx(grantIdx), .anyReq(anyReq)
  );
  assign word = reqData[grantIdx*DAC_BITS +: DAC_BITS];
  assign grantPot = grantIdx != CH_DAC;
  // Pot words are left-justified so both buses shift out of the same MSB
  assign loadWord = grantPot ? DAC_BITS'(word[POT_BITS-1:0]) << (DAC_BITS - POT_BITS) : word;
  assign {csDpot3, csDpot2, csDpot1} = csN;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      bitCnt <= '0;
      shiftReg <= '0;
      isPot <= 1'b0;
      reqAck <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      syncDac <= 1'b1;
      csN <= 3'b111;
      sclkDac <= 1'b0;
      clkDpot <= 1'b0;
      sdiDac <= 1'b0;
      sdiDpot <= 1'b0;
    end else begin
      reqAck <= '0;
      done <= 1'b0;
      cnt <= cnt - 1'b1;
      case (state)
        ST_IDLE: if (anyReq) begin
          state <= ST_SETUP;
          cnt <= CNT_W'(CS_SETUP - 1);
          bitCnt <= grantPot ? BCW'(POT_BITS) : BCW'(DAC_BITS);
          shiftReg <= loadWord;
          isPot <= grantPot;
          reqAck <= grant;
          busy <= 1'b1;
          syncDac <= grantPot;
          csN <= ~grant[3:1];
          sdiDac <= !grantPot && loadWord[DAC_BITS-1];
          sdiDpot <= grantPot && loadWord[DAC_BITS-1];
        end
        ST_SETUP, ST_SHIFT_LO: if (cnt == '0) begin
          if (state == ST_SHIFT_LO && bitCnt == '0) begin
            state <= ST_HOLD;
            cnt <= CNT_W'(CS_HOLD - 1);
          end else begin
            state <= ST_SHIFT_HI;
            cnt <= CNT_W'(CLK_DIV - 1);
            sclkDac <= !isPot;
            clkDpot <= isPot;
          end
        end
        ST_SHIFT_HI: if (cnt == '0) begin
          state <= ST_SHIFT_LO;
          cnt <= CNT_W'(CLK_DIV - 1);
          bitCnt <= bitCnt - 1'b1;
          shiftReg <= shiftReg << 1;
          sclkDac <= 1'b0;
          clkDpot <= 1'b0;
          sdiDac <= !isPot && shiftReg[DAC_BITS-2];
          sdiDpot <= isPot && shiftReg[DAC_BITS-2];
        end
        ST_HOLD: if (cnt == '0) begin
          state <= ST_GAP;
          cnt <= CNT_W'(GAP - 1);
          syncDac <= 1'b1;
          csN <= 3'b111;
          sdiDac <= 1'b0;
          sdiDpot <= 1'b0;
          done <= 1'b1;
        end
        ST_GAP: if (cnt == '0) begin
          state <= ST_IDLE;
          busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wac_spi_scheduler.sv
// tb_wac_spi_scheduler: waveform-level model of frames plus directed scenarios with literal checks
module tb_wac_spi_scheduler;
  localparam int D = 2, S = 2, H = 2, G = 4, DB = 24, PB = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] reqValid = '0;
  logic [4*DB-1:0] reqData = '0;
  logic [3:0] reqAck;
  logic busy, done, syncDac, sclkDac, sdiDac, csDpot1, csDpot2, csDpot3, clkDpot, sdiDpot;
  int nChecks = 0, nFails = 0;

  wac_spi_scheduler dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqData(reqData), .reqAck(reqAck),
    .busy(busy), .done(done), .syncDac(syncDac), .sclkDac(sclkDac), .sdiDac(sdiDac),
    .csDpot1(csDpot1), .csDpot2(csDpot2), .csDpot3(csDpot3), .clkDpot(clkDpot), .sdiDpot(sdiDpot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int frameLen(input int ch);
    return S + 2 * D * (ch == 0 ? DB : PB) + H;
  endfunction

  // Model: which frame is on the wire, decided from the arbitration rules
  int cyc = 0, mT0 = 0, mCh = 0, mPtr = 0, mFree = 0;
  bit mActive = 0;
  logic [DB-1:0] mWord = '0;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mActive = 0;
      mPtr = 0;
      mFree = cyc + 1;
    end else if (cyc >= mFree && reqValid != 0) begin
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (mPtr + i) % 4;
        if (reqValid[c]) begin
          mCh = c;
          break;
        end
      end
      mT0 = cyc;
      mWord = reqData[mCh*DB +: DB];
      mPtr = (mCh + 1) % 4;
      mFree = cyc + frameLen(mCh) + G + 1;
      mActive = 1;
    end
  end

  // Compare + monitor, sampled 1 time unit after every rising edge
  int dacRises = 0, potRises = 0, dacLow = 0, potLow = 0, lastDacLow = 0, lastPotLow = 0;
  int doneCnt = 0, gapRun = 0, minGap = 1000;
  bit seenFrame = 0, pSclk = 0, pClk = 0;
  logic [31:0] capDac = '0, capPot = '0;
  int ackLog[$];
  always @(posedge clk) begin
    logic [3:0] eAck, eSel;
    logic eBusy, eDone, eSclk, eSdi;
    logic [13:0] expv, act;
    int o, bits, len, idx;
    #1;
    eAck = '0; eSel = 4'hF; eBusy = 0; eDone = 0; eSclk = 0; eSdi = 0;
    if (mActive) begin
      o = cyc - mT0;
      bits = mCh == 0 ? DB : PB;
      len = frameLen(mCh);
      eBusy = o < len + G;
      eDone = o == len;
      if (o == 0) eAck[mCh] = 1'b1;
      if (o < len) begin
        eSel[mCh] = 1'b0;
        eSclk = o >= S && o < S + 2 * D * bits && (o - S) % (2 * D) < D;
        idx = o < S + D ? bits - 1 : bits - 2 - (o - S - D) / (2 * D);
        eSdi = idx >= 0 ? mWord[idx] : 1'b0;
      end
    end
    expv = {eAck, eBusy, eDone, eSel[0], mCh == 0 && eSclk, mCh == 0 && eSdi,
            eSel[1], eSel[2], eSel[3], mCh != 0 && eSclk, mCh != 0 && eSdi};
    act = {reqAck, busy, done, syncDac, sclkDac, sdiDac, csDpot1, csDpot2, csDpot3, clkDpot, sdiDpot};
    chk($sformatf("pins@%0d", cyc), 32'(act), 32'(expv));
    chk("oneSelect", 32'($countones({~syncDac, ~csDpot1, ~csDpot2, ~csDpot3}) <= 1), 32'd1);
    if (sclkDac && !pSclk) begin dacRises++; capDac = {capDac[30:0], sdiDac}; end
    if (clkDpot && !pClk) begin potRises++; capPot = {capPot[30:0], sdiDpot}; end
    pSclk = sclkDac;
    pClk = clkDpot;
    if (!syncDac) dacLow++;
    else if (dacLow > 0) begin lastDacLow = dacLow; dacLow = 0; end
    if (!(csDpot1 && csDpot2 && csDpot3)) potLow++;
    else if (potLow > 0) begin lastPotLow = potLow; potLow = 0; end
    if (syncDac && csDpot1 && csDpot2 && csDpot3) gapRun++;
    else begin
      if (seenFrame && gapRun > 0 && gapRun < minGap) minGap = gapRun;
      seenFrame = 1;
      gapRun = 0;
    end
    for (int c = 0; c < 4; c++) if (reqAck[c]) ackLog.push_back(c);
    if (done) doneCnt++;
  end

  task automatic waitAck(input int ch);
    int n = 0;
    while (reqAck[ch] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (reqAck[ch] !== 1'b1) begin nFails++; $display("FAIL ackTimeout ch%0d: no ack within 1000 cycles", ch); end
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    if (busy !== 1'b0) begin nFails++; $display("FAIL idleTimeout: busy still %b", busy); end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int baseD, baseP, baseDone, baseAck, n;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rstSelects", 32'({syncDac, csDpot1, csDpot2, csDpot3}), 32'hF);
    chk("rstClocks", 32'({sclkDac, clkDpot, sdiDac, sdiDpot}), 32'h0);
    chk("rstStatus", 32'({reqAck, busy, done}), 32'h0);
    // 1: DAC frame
    baseD = dacRises; baseP = potRises; baseDone = doneCnt;
    reqData[0 +: DB] = 24'hA50F3C;
    reqValid = 4'b0001;
    waitAck(0);
    reqValid = '0;
    waitIdle();
    chk("dacLowLen", 32'(lastDacLow), 32'd100);
    chk("dacRises", 32'(dacRises - baseD), 32'd24);
    chk("dacBits", capDac[23:0], 32'hA50F3C);
    chk("dacDone", 32'(doneCnt - baseDone), 32'd1);
    chk("potQuiet", 32'(potRises - baseP), 32'd0);
    // 2: POT2 frame
    baseD = dacRises; baseP = potRises;
    reqData[2*DB +: DB] = 24'h001234;
    reqValid = 4'b0100;
    waitAck(2);
    reqValid = '0;
    waitIdle();
    chk("potLowLen", 32'(lastPotLow), 32'd68);
    chk("potRises", 32'(potRises - baseP), 32'd16);
    chk("potBits", capPot[15:0], 32'h1234);
    chk("dacQuiet", 32'(dacRises - baseD), 32'd0);
    // 3: all four held, strict round robin from a fresh pointer
    doReset();
    reqData = {24'h00C3C3, 24'h00F00F, 24'h005AA5, 24'h123456};
    reqValid = 4'b1111;
    baseAck = ackLog.size();
    n = 0;
    while (ackLog.size() < baseAck + 5 && n < 2000) begin @(negedge clk); n++; end
    reqValid = '0;
    waitIdle();
    for (int i = 0; i < 5; i++)
      chk($sformatf("rrOrder%0d", i), 32'(ackLog.size() > baseAck + i ? ackLog[baseAck+i] : -1), 32'(order[i]));
    chk("minGapGe4", 32'(minGap >= 4), 32'd1);
    // 4: reset at the 10th DAC rise, pending request restarts from the MSB
    reqData[0 +: DB] = 24'h3C96A5;
    reqValid = 4'b0001;
    baseD = dacRises;
    n = 0;
    while (dacRises < baseD + 10 && n < 1000) begin @(negedge clk); n++; end
    chk("tenthRise", 32'(dacRises - baseD), 32'd10);
    rst_n = 1'b0;
    baseDone = doneCnt;
    @(negedge clk);
    chk("abortSync", 32'({syncDac, sclkDac, busy}), 32'h4);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    waitAck(0);
    reqValid = '0;
    waitIdle();
    chk("restartBits", capDac[23:0], 32'h3C96A5);
    chk("restartRises", 32'(dacRises - baseD), 32'd34);
    chk("abortNoDone", 32'(doneCnt - baseDone), 32'd1);
    chk("restartLowLen", 32'(lastDacLow), 32'd100);
    // 5: short pulse while busy is ignored, data edits after ack do not leak
    baseAck = ackLog.size();
    reqData[3*DB +: DB] = 24'h00BEEF;
    reqValid = 4'b1000;
    waitAck(3);
    reqValid = '0;
    repeat (10) @(negedge clk);
    reqValid = 4'b0010;
    reqData[3*DB +: DB] = 24'h005555;
    @(negedge clk);
    reqValid = '0;
    waitIdle();
    repeat (10) @(negedge clk);
    chk("potHoldBits", capPot[15:0], 32'hBEEF);
    chk("pulseIgnored", 32'(ackLog.size() - baseAck), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
